// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the unified memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_priority.sv
// rtl/mem_arb_priority.sv - fetch/data tie-break with starvation counter
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output gnt_e gnt,
  output logic valid
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] lose_cnt;
  logic          starved;

  assign starved = (lose_cnt == CW'(STARVE_MAX));

  // Data wins ties until fetch has lost STARVE_MAX arbitrations in a row.
  always_comb begin
    valid = i_req | d_req;
    gnt   = (i_req && (!d_req || starved)) ? GNT_I : GNT_D;
  end

  // Counter never passes STARVE_MAX: at that value a pending fetch wins and clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lose_cnt <= '0;
    end else if (take && valid) begin
      if (gnt == GNT_I) begin
        lose_cnt <= '0;
      end else if (i_req) begin
        lose_cnt <= lose_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-ported memory shared by fetch and load/store ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e        state;
  gnt_e          gnt_q;
  gnt_e          gnt;
  logic          valid;
  logic          take;
  logic          we_q;
  logic [LW-1:0] lat_cnt;

  assign take = (state == IDLE);

  mem_arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) u_priority (
    .clk  (clk),
    .reset(reset),
    .i_req(i_req),
    .d_req(d_req),
    .take (take),
    .gnt  (gnt),
    .valid(valid)
  );

  // m_* and acks default low each cycle so they are only seen in ISSUE / RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt_q   <= GNT_I;
      we_q    <= 1'b0;
      lat_cnt <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      case (state)
        IDLE: begin
          if (valid) begin
            gnt_q <= gnt;
            state <= ISSUE;
            m_en  <= 1'b1;
            if (gnt == GNT_D) begin
              we_q    <= d_we;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              we_q   <= 1'b0;
              m_addr <= i_addr;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LW'(MEM_LATENCY - 1);
          state   <= WAIT;
        end
        WAIT: begin
          // Last WAIT cycle is the one where m_rdata is valid.
          if (lat_cnt == '0) begin
            state <= RESP;
            if (gnt_q == GNT_I) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_ack <= 1'b1;
              if (!we_q) begin
                d_rdata <= m_rdata;
              end
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with memory and arbitration model
module tb_mem_arbiter;

  localparam int L = 2;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, d_ack, m_en, m_we;

  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0, m_rdata1 = '0;
  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        i_ack1, d_ack1, m_en1, m_we1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(L), .STARVE_MAX(S)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
  );

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          m_en_cnt = 0;
  logic [31:0] mem[64];
  logic [31:0] ref_mem[64];
  logic [31:0] last_d = '0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int          rd_due[$];
  logic [31:0] rd_dat[$];
  bit          ack_port[$];
  int          ack_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got nothing, required an event (cycle %0d)", name, cyc);
  endtask

  // Memory: writes land at m_en, reads return exactly L cycles later, junk otherwise.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      rd_due.delete();
      rd_dat.delete();
    end else if (m_en) begin
      if (m_we) mem[m_addr[7:2]] = m_wdata;
      else begin
        rd_due.push_back(cyc + L);
        rd_dat.push_back(mem[m_addr[7:2]]);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      m_rdata = rd_dat.pop_front();
      void'(rd_due.pop_front());
    end else begin
      m_rdata = $urandom;
    end
  end

  // Monitor: arbitration model on requests seen at the previous edge, timing and data scoreboard.
  initial begin : monitor
    logic        pi, pd, pdwe, w, inflight, in_port;
    logic [31:0] pia, pda, pdwd;
    int          lose, issue_cyc;
    pi = 0; pd = 0; pdwe = 0; pia = 0; pda = 0; pdwd = 0;
    lose = 0; inflight = 0; in_port = 0; issue_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        inflight = 0;
        exp_i.delete();
        exp_d.delete();
        lose = 0;
        pi = 0;
        pd = 0;
      end else begin
        if (m_en) begin
          m_en_cnt++;
          check("grant_overlap", {31'b0, inflight}, 0);
          check("grant_without_req", {31'b0, pi | pd}, 1);
          w = (pi && pd) ? (lose != S) : pd;
          if (w) begin
            if (pi) lose++;
          end else begin
            lose = 0;
          end
          check("m_addr", m_addr, w ? pda : pia);
          check("m_we", {31'b0, m_we}, {31'b0, w & pdwe});
          if (w && pdwe) check("m_wdata", m_wdata, pdwd);
          inflight = 1;
          in_port = w;
          issue_cyc = cyc;
        end else begin
          check("m_idle_zero", {31'b0, m_we || m_addr != 0 || m_wdata != 0}, 0);
        end
        if (i_ack || d_ack) begin
          check("ack_onehot", {31'b0, i_ack & d_ack}, 0);
          check("ack_expected", {31'b0, inflight}, 1);
          if (inflight) begin
            check("ack_port", {31'b0, d_ack}, {31'b0, in_port});
            check("ack_cycle", cyc, issue_cyc + L + 1);
          end
          if (i_ack) begin
            if (exp_i.size() == 0) fail("i_ack_unexpected");
            else check("i_rdata", i_rdata, exp_i.pop_front());
          end
          if (d_ack) begin
            if (exp_d.size() == 0) fail("d_ack_unexpected");
            else check("d_rdata", d_rdata, exp_d.pop_front());
          end
          ack_port.push_back(d_ack);
          ack_cyc.push_back(cyc);
          inflight = 0;
        end
        pi = i_req; pd = d_req; pia = i_addr; pda = d_addr; pdwe = d_we; pdwd = d_wdata;
      end
    end
  end

  // Issue one request at the current cycle (called #1 after a rising edge), wait for its ack.
  task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit keep, output int lat);
    int start;
    bit got;
    start = cyc;
    if (!port) begin
      i_addr = addr;
      i_req = 1;
      exp_i.push_back(ref_mem[addr[7:2]]);
    end else begin
      d_we = we;
      d_addr = addr;
      d_wdata = wdata;
      d_req = 1;
      if (we) ref_mem[addr[7:2]] = wdata;
      else last_d = ref_mem[addr[7:2]];
      exp_d.push_back(last_d);
    end
    got = 0;
    lat = -1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (port ? d_ack : i_ack) begin
        got = 1;
        lat = cyc - start;
      end
    end
    if (!got) fail(port ? "d_ack_timeout" : "i_ack_timeout");
    @(posedge clk);
    #1;
    if (!keep) begin
      if (port) d_req = 0;
      else i_req = 0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, lat2, la, lb, base, start2, en0, gap;
    bit exp_seq[6];
    exp_seq = '{1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4] = 32'h2002_0005;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {28'b0, i_ack, d_ack, m_en, m_we}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;

    txn(0, 0, 32'h10, 0, 0, lat);
    check("fetch_latency", lat, L + 2);
    check("fetch_rdata_hold", i_rdata, 32'h2002_0005);

    txn(1, 1, 32'd84, 32'd7, 0, lat);
    check("write_latency", lat, L + 2);
    check("write_keeps_d_rdata", d_rdata, 0);

    base = cyc;
    en0 = m_en_cnt;
    txn(1, 0, 32'd80, 0, 1, lat);
    start2 = cyc;
    txn(1, 0, 32'd84, 0, 0, lat2);
    check("b2b_first_ack", lat, 4);
    check("b2b_second_ack", start2 + lat2 - base, 9);
    check("b2b_m_en_count", m_en_cnt - en0, 2);
    check("b2b_last_data", d_rdata, 7);

    ack_port.delete();
    ack_cyc.delete();
    fork
      begin
        txn(0, 0, 32'd8, 0, 1, la);
        txn(0, 0, 32'd12, 0, 0, la);
      end
      begin
        txn(1, 0, 32'd128, 0, 1, lb);
        txn(1, 1, 32'd132, 32'h55, 1, lb);
        txn(1, 0, 32'd132, 0, 1, lb);
        txn(1, 0, 32'd136, 0, 0, lb);
      end
    join
    check("contend_acks", ack_port.size(), 6);
    for (int k = 0; k < 6 && k < ack_port.size(); k++) begin
      check($sformatf("contend_order_%0d", k), {31'b0, ack_port[k]}, {31'b0, exp_seq[k]});
      if (k > 0) check($sformatf("contend_gap_%0d", k), ack_cyc[k] - ack_cyc[k-1], 5);
    end

    base = cyc;
    i_addr = 32'h14;
    i_req = 1;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 0;
    #1;
    check("rst_mid_ctrl", {28'b0, i_ack, d_ack, m_en, m_we}, 0);
    check("rst_mid_m_addr", m_addr, 0);
    check("rst_mid_i_rdata", i_rdata, 0);
    check("rst_mid_d_rdata", d_rdata, 0);
    i_req = 0;
    last_d = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_ack", {30'b0, i_ack, d_ack}, 0);
    end
    @(posedge clk);
    #1;
    txn(0, 0, 32'h14, 0, 0, lat);
    check("post_rst_latency", lat, 4);

    base = cyc;
    i_addr1 = 32'h20;
    i_req1 = 1;
    m_rdata1 = $urandom | 32'h1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("l1_m_en", {31'b0, m_en1}, {31'b0, k == 1});
      if (k == 1) check("l1_m_addr", m_addr1, 32'h20);
      check("l1_i_ack", {31'b0, i_ack1}, {31'b0, k == 3});
      if (k == 3) check("l1_i_rdata", i_rdata1, 32'hCAFE_F00E);
      @(posedge clk);
      #1;
      m_rdata1 = (cyc == base + 2) ? 32'hCAFE_F00E : ($urandom | 32'h1);
      if (k == 3) i_req1 = 0;
    end

    fork
      begin
        for (int n = 0; n < 30; n++) begin
          txn(0, 0, {24'b0, 1'b0, 5'($urandom_range(0, 31)), 2'b00}, 0, 0, la);
          gap = $urandom_range(0, 3);
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int n = 0; n < 30; n++) begin
          txn(1, 1'($urandom_range(0, 1)), {24'b0, 1'b1, 5'($urandom_range(0, 31)), 2'b00},
              $urandom, 0, lb);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    check("exp_i_drained", exp_i.size(), 0);
    check("exp_d_drained", exp_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
